iq_modulation: RTL and testbench

//  Transmit-side quadrature up-converter: mixes a complex baseband stream (I_BB, Q_BB) up to IF

---
 rtl/iq_pkg.sv | 22 ++
 rtl/lo_quadrature_gen.sv | 48 ++++
 rtl/iq_modulation.sv | 104 ++++++++++
 tb/tb_iq_modulation.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
// Shared types and helpers for the fs/4 quadrature mixer path (TX modulator and RX demodulator).
// Sample width, LO phase encoding and the saturating negate used by the mix stage.
package iq_pkg;

   localparam int IQ_W = 5;

   typedef enum logic [1:0] {PH0, PH1, PH2, PH3} lo_phase_t;

   localparam logic signed [IQ_W:0] IQ_MAX = {2'b00, {(IQ_W-1){1'b1}}};

   // Negate at W+1 bits so -(-2^(W-1)) clamps to +max instead of wrapping.
   function automatic logic signed [IQ_W-1:0] sat_neg(input logic signed [IQ_W-1:0] x);
      logic signed [IQ_W:0] n;
      n = {x[IQ_W-1], x};
      n = -n;
      if (n > IQ_MAX) begin
         return IQ_MAX[IQ_W-1:0];
      end
      return n[IQ_W-1:0];
   endfunction

endpackage

// File: rtl/lo_quadrature_gen.sv
// fs/4 LO phase generator: steps PH0..PH3 once per advance, reloads PHASE_INIT on phase_clr.
// Outputs the phase in effect this cycle (clear already applied) with its cos/sin pair.
module lo_quadrature_gen
   import iq_pkg::*;
#(
   parameter int PHASE_INIT = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              phase_clr,
   input  logic              advance,
   output lo_phase_t         phase,
   output logic signed [1:0] lo_cos,
   output logic signed [1:0] lo_sin
);

   localparam lo_phase_t INIT_PH = lo_phase_t'(PHASE_INIT[1:0]);

   lo_phase_t state_q, state_d, cur;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= INIT_PH;
      end else begin
         state_q <= state_d;
      end
   end

   // A clear coinciding with an advance uses INIT for this sample and INIT+1 afterwards.
   always_comb begin
      cur     = phase_clr ? INIT_PH : state_q;
      state_d = cur;
      lo_cos  = 2'sb00;
      lo_sin  = 2'sb00;
      if (advance) begin
         state_d = lo_phase_t'(cur + 2'd1);
      end
      case (cur)
         PH0:     lo_cos = 2'sb01;
         PH1:     lo_sin = 2'sb01;
         PH2:     lo_cos = 2'sb11;
         default: lo_sin = 2'sb11;
      endcase
   end

   assign phase = cur;

endmodule

// File: rtl/iq_modulation.sv
// TX quadrature up-converter: I_IF = I*cos - Q*sin, Q_IF = I*sin + Q*cos with an fs/4 LO.
// Two registered stages (sample+LO, then mixed/saturated result); stalls only when both are full.
module iq_modulation
   import iq_pkg::*;
#(
   parameter int W          = IQ_W,
   parameter int PHASE_INIT = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                phase_clr,
   input  logic signed [W-1:0] I_BB,
   input  logic signed [W-1:0] Q_BB,
   input  logic                bb_valid,
   output logic                bb_ready,
   output logic signed [W-1:0] I_IF,
   output logic signed [W-1:0] Q_IF,
   output logic                if_valid,
   input  logic                if_ready,
   output logic [1:0]          lo_phase
);

   localparam lo_phase_t INIT_PH = lo_phase_t'(PHASE_INIT[1:0]);

   logic                s1_vld_q;
   logic signed [W-1:0] s1_i_q, s1_q_q;
   logic signed [1:0]   s1_cos_q, s1_sin_q;
   lo_phase_t           s1_ph_q;

   logic                if_vld_q;
   logic signed [W-1:0] i_if_q, q_if_q, i_if_d, q_if_d;

   logic                stall, accept;
   lo_phase_t           lo_ph;
   logic signed [1:0]   lo_cos, lo_sin, nsin;

   assign stall    = if_vld_q && !if_ready;
   assign bb_ready = !(s1_vld_q && stall);
   assign accept   = bb_valid && bb_ready;

   lo_quadrature_gen #(.PHASE_INIT(PHASE_INIT)) u_lo (
      .clk       (clk),
      .reset     (reset),
      .phase_clr (phase_clr),
      .advance   (accept),
      .phase     (lo_ph),
      .lo_cos    (lo_cos),
      .lo_sin    (lo_sin)
   );

   function automatic logic signed [W-1:0] unit_mul(input logic signed [W-1:0] x,
                                                    input logic signed [1:0]   c);
      case (c)
         2'sb01:  return x;
         2'sb11:  return sat_neg(x);
         default: return '0;
      endcase
   endfunction

   // Only one LO term is nonzero per phase, so the W-bit sum cannot overflow.
   always_comb begin
      nsin   = -s1_sin_q;
      i_if_d = unit_mul(s1_i_q, s1_cos_q) + unit_mul(s1_q_q, nsin);
      q_if_d = unit_mul(s1_i_q, s1_sin_q) + unit_mul(s1_q_q, s1_cos_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vld_q <= 1'b0;
         s1_i_q   <= '0;
         s1_q_q   <= '0;
         s1_cos_q <= '0;
         s1_sin_q <= '0;
         s1_ph_q  <= INIT_PH;
         if_vld_q <= 1'b0;
         i_if_q   <= '0;
         q_if_q   <= '0;
      end else begin
         if (bb_ready) begin
            s1_vld_q <= bb_valid;
         end
         if (accept) begin
            s1_i_q   <= I_BB;
            s1_q_q   <= Q_BB;
            s1_cos_q <= lo_cos;
            s1_sin_q <= lo_sin;
            s1_ph_q  <= lo_ph;
         end
         if (!stall) begin
            if_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
               i_if_q <= i_if_d;
               q_if_q <= q_if_d;
            end
         end
      end
   end

   assign I_IF     = i_if_q;
   assign Q_IF     = q_if_q;
   assign if_valid = if_vld_q;
   assign lo_phase = s1_ph_q;

endmodule

// File: tb/tb_iq_modulation.sv
// Bench for iq_modulation: two instances (PHASE_INIT 0 and 2) share stimulus; a queue model
// predicts every output cycle, plus literal expectations for the directed scenarios.
module tb_iq_modulation;

   localparam int W    = 5;
   localparam int MAXV = (1 << (W-1)) - 1;
   localparam int MINV = -(1 << (W-1));

   logic clk = 1'b0, reset = 1'b1, phase_clr = 1'b0, bb_valid = 1'b0, if_ready = 1'b1;
   logic signed [W-1:0] I_BB = '0, Q_BB = '0;
   logic rdy0, rdy2, v0, v2;
   logic signed [W-1:0] i0, q0, i2, q2;
   logic [1:0] ph0o, ph2o;

   always #5 clk = ~clk;

   iq_modulation #(.W(W), .PHASE_INIT(0)) dut0 (
      .clk(clk), .reset(reset), .phase_clr(phase_clr), .I_BB(I_BB), .Q_BB(Q_BB),
      .bb_valid(bb_valid), .bb_ready(rdy0), .I_IF(i0), .Q_IF(q0), .if_valid(v0),
      .if_ready(if_ready), .lo_phase(ph0o));

   iq_modulation #(.W(W), .PHASE_INIT(2)) dut2 (
      .clk(clk), .reset(reset), .phase_clr(phase_clr), .I_BB(I_BB), .Q_BB(Q_BB),
      .bb_valid(bb_valid), .bb_ready(rdy2), .I_IF(i2), .Q_IF(q2), .if_valid(v2),
      .if_ready(if_ready), .lo_phase(ph2o));

   typedef struct {int cyc; int ei0; int eq0; int ei2; int eq2;} entry_t;
   entry_t exp_q[$];
   int log_i0[$], log_q0[$], log_i2[$], log_q2[$];

   int n_checks = 0, n_fail = 0, cyc = 0, acc_count = 0;
   int mph0 = 0, mph2 = 2, lp0 = 0, lp2 = 2;
   int first_acc = -1, first_vld = -1;
   bit seen_rst = 0;

   function automatic int clamp(input int v);
      if (v > MAXV) return MAXV;
      if (v < MINV) return MINV;
      return v;
   endfunction

   // Rotation by p quarter turns of the complex sample (I + jQ).
   function automatic int mix_i(input int i, input int q, input int p);
      case (p)
         0: return clamp(i);
         1: return clamp(-q);
         2: return clamp(-i);
         default: return clamp(q);
      endcase
   endfunction

   function automatic int mix_q(input int i, input int q, input int p);
      case (p)
         0: return clamp(q);
         1: return clamp(i);
         2: return clamp(-q);
         default: return clamp(-i);
      endcase
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      int n, u0, u2;
      bit ev, s1, er;
      entry_t e;
      cyc++;
      if (reset) begin
         seen_rst = 1;
         exp_q.delete();
         mph0 = 0; mph2 = 2; lp0 = 0; lp2 = 2;
      end else if (seen_rst) begin
         n  = exp_q.size();
         ev = 0;
         if (n > 0) ev = (exp_q[0].cyc <= cyc - 2);
         check("if_valid0", int'(v0), int'(ev));
         check("if_valid2", int'(v2), int'(ev));
         s1 = (n - int'(ev)) >= 1;
         er = !(s1 && ev && !if_ready);
         check("bb_ready0", int'(rdy0), int'(er));
         check("bb_ready2", int'(rdy2), int'(er));
         check("lo_phase0", int'(ph0o), lp0);
         check("lo_phase2", int'(ph2o), lp2);
         if (v0 && first_vld < 0) first_vld = cyc;
         if (ev) begin
            check("I_IF0", int'(i0), exp_q[0].ei0);
            check("Q_IF0", int'(q0), exp_q[0].eq0);
            check("I_IF2", int'(i2), exp_q[0].ei2);
            check("Q_IF2", int'(q2), exp_q[0].eq2);
            if (if_ready) begin
               log_i0.push_back(int'(i0)); log_q0.push_back(int'(q0));
               log_i2.push_back(int'(i2)); log_q2.push_back(int'(q2));
               void'(exp_q.pop_front());
            end
         end
         if (bb_valid && er) begin
            u0 = phase_clr ? 0 : mph0;
            u2 = phase_clr ? 2 : mph2;
            e.cyc = cyc;
            e.ei0 = mix_i(int'(I_BB), int'(Q_BB), u0);
            e.eq0 = mix_q(int'(I_BB), int'(Q_BB), u0);
            e.ei2 = mix_i(int'(I_BB), int'(Q_BB), u2);
            e.eq2 = mix_q(int'(I_BB), int'(Q_BB), u2);
            exp_q.push_back(e);
            lp0 = u0; lp2 = u2;
            mph0 = (u0 + 1) % 4; mph2 = (u2 + 1) % 4;
            acc_count++;
            if (first_acc < 0) first_acc = cyc;
         end else if (phase_clr) begin
            mph0 = 0; mph2 = 2;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int i, input int q, input bit clr);
      bit acc;
      int guard;
      I_BB = W'(i); Q_BB = W'(q); bb_valid = 1'b1; phase_clr = clr;
      acc = 0; guard = 0;
      while (!acc && guard < 200) begin
         @(negedge clk);
         acc = rdy0;
         tick();
         guard++;
      end
      if (!acc) check("send_accept_timeout", 0, 1);
      phase_clr = 1'b0;
   endtask

   task automatic drain();
      int guard;
      bb_valid = 1'b0; phase_clr = 1'b0; if_ready = 1'b1;
      guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
         tick();
         guard++;
      end
      tick();
      check("drain_empty", exp_q.size(), 0);
   endtask

   task automatic clear_log();
      log_i0.delete(); log_q0.delete(); log_i2.delete(); log_q2.delete();
      first_acc = -1; first_vld = -1;
   endtask

   task automatic check_out(input string name, input int k,
                            input int ei0, input int eq0, input int ei2, input int eq2);
      if (k >= log_i0.size()) begin
         check({name, "_missing"}, log_i0.size(), k + 1);
      end else begin
         check({name, "_I0"}, log_i0[k], ei0);
         check({name, "_Q0"}, log_q0[k], eq0);
         check({name, "_I2"}, log_i2[k], ei2);
         check({name, "_Q2"}, log_q2[k], eq2);
      end
   endtask

   initial begin
      int t1_i0[4] = '{5, -3, -5, 3};
      int t1_q0[4] = '{3, 5, -3, -5};
      int t2_i0[4] = '{-16, 15, 15, -16};
      int t2_q0[4] = '{-16, -16, 15, 15};
      int t2_i2[4] = '{15, -16, -16, 15};
      int t2_q2[4] = '{15, 15, -16, -16};
      bit low_seen;
      int start_acc, guard;

      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst_if_valid", int'(v0), 0);
      check("rst_I_IF", int'(i0), 0);
      check("rst_Q_IF", int'(q0), 0);
      check("rst_lo_phase0", int'(ph0o), 0);
      check("rst_lo_phase2", int'(ph2o), 2);
      check("rst_bb_ready", int'(rdy0), 1);
      tick();

      // Basic stream, full throughput.
      clear_log();
      if_ready = 1'b1;
      for (int k = 0; k < 4; k++) send(5, 3, 1'b0);
      drain();
      for (int k = 0; k < 4; k++)
         check_out("t1", k, t1_i0[k], t1_q0[k], t1_i0[(k + 2) % 4], t1_q0[(k + 2) % 4]);
      check("t1_latency", first_vld - first_acc, 2);

      // Most-negative inputs at every phase.
      clear_log();
      for (int k = 0; k < 4; k++) send(-16, -16, 1'b0);
      drain();
      for (int k = 0; k < 4; k++)
         check_out("t2", k, t2_i0[k], t2_q0[k], t2_i2[k], t2_q2[k]);

      // Downstream stall for 5 cycles mid-stream.
      clear_log();
      start_acc = acc_count;
      for (int k = 1; k <= 3; k++) send(k, -k, 1'b0);
      if_ready = 1'b0;
      I_BB = W'(7); Q_BB = W'(-2); bb_valid = 1'b1;
      low_seen = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (!rdy0) low_seen = 1;
         tick();
      end
      check("t3_bb_ready_dropped", int'(low_seen), 1);
      drain();
      check("t3_no_loss", log_i0.size(), acc_count - start_acc);

      // Random valid/ready with occasional phase clears.
      start_acc = acc_count;
      guard = 0;
      while (acc_count - start_acc < 1000 && guard < 20000) begin
         bb_valid  = 1'($urandom % 2);
         I_BB      = W'($urandom);
         Q_BB      = W'($urandom);
         if_ready  = 1'($urandom % 2);
         phase_clr = ($urandom % 32) == 0;
         tick();
         guard++;
      end
      check("t4_enough_accepts", int'(acc_count - start_acc >= 1000), 1);
      drain();

      // phase_clr together with an accept.
      clear_log();
      send(1, 1, 1'b0);
      send(5, 3, 1'b1);
      send(5, 3, 1'b0);
      drain();
      check_out("t5a", 1, 5, 3, -5, -3);
      check_out("t5b", 2, -3, 5, 3, -5);

      // Reset with two samples in flight.
      if_ready = 1'b0;
      send(4, 1, 1'b0);
      send(4, 1, 1'b0);
      bb_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("t6_if_valid", int'(v0), 0);
      check("t6_I_IF", int'(i0), 0);
      check("t6_Q_IF", int'(q0), 0);
      check("t6_lo_phase2", int'(ph2o), 2);
      tick();
      if_ready = 1'b1;
      clear_log();
      send(6, 2, 1'b0);
      drain();
      check_out("t6", 0, 6, 2, -6, -2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
